// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main control: state codes, opcodes and control-field values.
// Optional addi support is enabled by defining MC_ADDI_EN.
package mc_pkg;

    localparam int ST_W = 4;

    localparam logic [ST_W-1:0] S_FETCH  = 4'd0;
    localparam logic [ST_W-1:0] S_DECODE = 4'd1;
    localparam logic [ST_W-1:0] S_MEMADR = 4'd2;
    localparam logic [ST_W-1:0] S_MEMRD  = 4'd3;
    localparam logic [ST_W-1:0] S_MEMWB  = 4'd4;
    localparam logic [ST_W-1:0] S_MEMWR  = 4'd5;
    localparam logic [ST_W-1:0] S_EXEC   = 4'd6;
    localparam logic [ST_W-1:0] S_RWB    = 4'd7;
    localparam logic [ST_W-1:0] S_BRANCH = 4'd8;
    localparam logic [ST_W-1:0] S_JUMP   = 4'd9;
    localparam logic [ST_W-1:0] S_ADDIEX = 4'd10;
    localparam logic [ST_W-1:0] S_ADDIWB = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> control word decode; unlisted fields and unused state codes give all zeros.
// ADDIEX/ADDIWB decode only when MC_ADDI_EN is defined.
module mc_output_decode
    import mc_pkg::*;
(
    input  logic [ST_W-1:0] state,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic and reset gating of strobes.
// Optional addi path (DECODE -> ADDIEX -> ADDIWB) is built when MC_ADDI_EN is defined.
module mc_main_control
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALU_op,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               InstrDone,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] State
);

    logic [ST_W-1:0] state_q;
    logic [ST_W-1:0] state_nxt;
    logic            op_illegal;
    ctrl_t           ctrl;

    always_comb begin
        state_nxt  = S_FETCH;
        op_illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:      state_nxt = S_EXEC;
                    OP_LW, OP_SW:  state_nxt = S_MEMADR;
                    OP_BEQ:        state_nxt = S_BRANCH;
                    OP_J:          state_nxt = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:       state_nxt = S_ADDIEX;
`endif
                    default:       op_illegal = 1'b1;
                endcase
            end
            // Opcode is stable here, so only lw/sw can arrive; anything else is abandoned.
            S_MEMADR: begin
                if (Opcode == OP_LW)
                    state_nxt = S_MEMRD;
                else if (Opcode == OP_SW)
                    state_nxt = S_MEMWR;
            end
            S_MEMRD:  state_nxt = S_MEMWB;
            S_EXEC:   state_nxt = S_RWB;
`ifdef MC_ADDI_EN
            S_ADDIEX: state_nxt = S_ADDIWB;
`endif
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_FETCH;
        else
            state_q <= state_nxt;
    end

    mc_output_decode u_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // Strobes are gated by reset so the pre-reset state cannot write during the reset cycle.
    assign PCWrite     = ctrl.pc_write      & ~reset;
    assign PCWriteCond = ctrl.pc_write_cond & ~reset;
    assign MemRead     = ctrl.mem_read      & ~reset;
    assign MemWrite    = ctrl.mem_write     & ~reset;
    assign IRWrite     = ctrl.ir_write      & ~reset;
    assign RegWrite    = ctrl.reg_write     & ~reset;
    assign InstrDone   = ctrl.instr_done    & ~reset;
    assign IllegalOp   = op_illegal         & ~reset;

    assign IorD     = ctrl.iord;
    assign MemtoReg = ctrl.mem_to_reg;
    assign PCSource = ctrl.pc_source;
    assign ALU_op   = ctrl.alu_op;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign RegDst   = ctrl.reg_dst;
    assign State    = STATE_W'(state_q);

endmodule
